// File: rtl/jk_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_seq_pkg
//  Description : Op codes, FSM encoding and helpers shared by the JK sequencer.
//  Revision    : 1.0
// ============================================================================
package jk_seq_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_UP     = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_TOGGLE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // CLEAR and LOAD reach their final value in one step, so they never repeat.
    function automatic logic is_single_step(input logic [2:0] op);
        return (op == OP_CLEAR) || (op == OP_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank
//  Description : WIDTH independent JK flip-flops, async active-high reset to 0.
//  Revision    : 1.0
// ============================================================================
module jk_bank #(
    parameter int WIDTH = 4
) (
    input  logic             Clck,
    input  logic             Reset,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    // Characteristic equation: 00 hold, 01 reset, 10 set, 11 toggle.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            r_q <= '0;
        end else begin
            r_q <= (J & ~r_q) | (~K & r_q);
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jk_seq_ctrl
//  Description : Command-driven sequencer producing J/K excitation for a bank.
//  Revision    : 1.0
// ============================================================================
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clck,
    input  logic             Reset,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic [2:0]       Cmd_op,
    input  logic [WIDTH-1:0] Cmd_data,
    input  logic [CNT_W-1:0] Cmd_count,
    output logic [WIDTH-1:0] J_out,
    output logic [WIDTH-1:0] K_out,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_dn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // Toggle enables of a ripple counter: bit i flips when all lower bits are 1 (up) / 0 (down).
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        if (i == 0) begin : g_lsb
            assign w_t_up[i] = 1'b1;
            assign w_t_dn[i] = 1'b1;
        end else begin : g_upper
            assign w_t_up[i] = &w_q[i-1:0];
            assign w_t_dn[i] = &(~w_q[i-1:0]);
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_HOLD: begin
                    w_j = '0;
                    w_k = '0;
                end
                OP_CLEAR: begin
                    w_k = '1;
                end
                OP_LOAD: begin
                    w_j = r_data;
                    w_k = ~r_data;
                end
                OP_UP: begin
                    w_j = w_t_up;
                    w_k = w_t_up;
                end
                OP_DOWN: begin
                    w_j = w_t_dn;
                    w_k = w_t_dn;
                end
                OP_TOGGLE: begin
                    w_j = '1;
                    w_k = '1;
                end
                default: begin
                    w_j = '0;
                    w_k = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_accept    = 1'b0;
        Cmd_ready   = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Cmd_ready = ~Reset;
                w_accept  = Cmd_valid;
                if (Cmd_valid) begin
                    if (Cmd_count == '0) begin
                        w_state_nxt = ST_DONE;
                        w_rem_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_EXEC;
                        w_rem_nxt   = is_single_step(Cmd_op) ? CNT_W'(1) : Cmd_count;
                    end
                end
            end
            ST_EXEC: begin
                Busy      = 1'b1;
                w_rem_nxt = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_op    <= OP_HOLD;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_accept) begin
                r_op   <= Cmd_op;
                r_data <= Cmd_data;
            end
        end
    end

    jk_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .Clck  (Clck),
        .Reset (Reset),
        .J     (w_j),
        .K     (w_k),
        .Q     (w_q)
    );

    assign J_out = w_j;
    assign K_out = w_k;
    assign Q     = w_q;

endmodule
`default_nettype wire

// File: doc/jk_seq_ctrl.md
Name: jk_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit bank of JK flip-flops.
- Accepts one command at a time over a valid/ready handshake.
- Generates per-bit J/K excitation each cycle to hold, clear, load, count up, count down or toggle the bank for a programmed number of steps.
- Sits between a command source (bench or higher-level FSM) and the JK storage; exposes bank state Q and the J/K drive for observation.

Parameters:
- WIDTH, 4, number of JK cells in the bank.
- CNT_W, 8, width of the step-count field.

Ports:
- Clck  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Cmd_valid  input  1  command present.
- Cmd_ready  output  1  controller can accept a command.
- Cmd_op  input  3  operation code.
- Cmd_data  input  WIDTH  load value (LOAD only).
- Cmd_count  input  CNT_W  number of steps to execute.
- J_out  output  WIDTH  J excitation currently applied to the bank.
- K_out  output  WIDTH  K excitation currently applied to the bank.
- Q  output  WIDTH  bank state.
- Busy  output  1  high while executing.
- Done  output  1  one-cycle pulse at command completion.

Behaviour:
- Clock and reset: one clock (Clck). Reset is asynchronous and active-high.
- Reset values: Q=0, Busy=0, Done=0, J_out=0, K_out=0, Cmd_ready=0 while Reset high, step counter=0, FSM=IDLE. Reset asserted mid-command aborts immediately with no completion pulse. Cmd_ready=1 in the first cycle after deassert.
- Op codes:
  - 0 HOLD
  - 1 CLEAR
  - 2 LOAD
  - 3 UP
  - 4 DOWN
  - 5 TOGGLE
  - 6/7 behave as HOLD.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Cmd_ready=1, Busy=0, J/K=0.
  - Accept on rising edge with Cmd_valid&Cmd_ready; capture op, data, count.
  - If captured count=0, go to DONE. Otherwise go to EXEC with remaining=count.
  - CLEAR and LOAD force remaining=1 when count is nonzero.
- EXEC:
  - Busy=1, Cmd_ready=0.
  - J/K are combinational from captured op, captured data and current Q.
  - The bank updates on every edge.
  - remaining decrements each edge; on the edge where remaining==1, go to DONE.
- DONE:
  - Done=1, Busy=0, Cmd_ready=0, J/K=0.
  - Unconditionally go to IDLE next edge.
- Excitation per bit i:
  - HOLD: J=0, K=0.
  - CLEAR: J=0, K=1.
  - LOAD: J=data[i], K=~data[i].
  - TOGGLE: J=K=1.
  - UP: J=K=t_i, where t_0=1 and t_i=&Q[i-1:0].
  - DOWN: J=K=t_i, where t_0=1 and t_i=&~Q[i-1:0].
- Wrap-around: counting wraps modulo 2^WIDTH with no flag (UP from all-ones gives 0; DOWN from 0 gives all-ones).
- Latency: accept edge to Done high is N+1 cycles for N>0, and 1 cycle for N=0. Q holds its final value while Done=1.
- Commands while busy: Cmd_valid held while not ready is ignored, not queued. Fields may change freely outside the accept edge.
- Back-to-back: minimum spacing between accepts is N+2 cycles (IDLE re-entered after DONE).

Decomposition:
- Shared package jk_seq_pkg:
  - op-code constants (OP_HOLD..OP_TOGGLE)
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_DONE).
- Sub-module jk_bank:
  - WIDTH JK flip-flops with async active-high reset to 0.
  - Ports: Clck, Reset, J, K, Q.
  - Standard JK semantics: 00 hold, 01 reset, 10 set, 11 toggle.
- jk_seq_ctrl contains the FSM, step counter, excitation logic, and one jk_bank instance.

Test Plan:
- Reset, then LOAD data=4'hA count=1 -> in the EXEC cycle J_out=4'hA, K_out=4'h5; Done pulses 2 cycles after accept; Q=4'hA; Cmd_ready returns 1 the cycle after Done.
- Q=4'hE, UP count=3 -> Q sequence F,0,1 on successive edges; Done with Q=4'h1; Busy high exactly 3 cycles.
- Q=4'h0, DOWN count=2 -> Q F then E; Done with Q=4'hE. Then CLEAR count=7 -> single step, Q=0, Done 2 cycles after accept.
- Q=4'h5, TOGGLE count=2 -> Q A then 5. Op=7 count=3 -> Q stays 5, Done after 4 cycles.
- UP count=0 -> Done 1 cycle after accept, Q unchanged, J/K never nonzero. Cmd_valid held high across a count=4 command -> exactly one accept per IDLE visit.
- UP count=10 from 0, Reset pulsed mid-cycle after 3 steps -> Q=0, Busy=0, Done=0 immediately with no Done pulse; after deassert a LOAD 4'h3 count=1 is accepted and completes normally.
